// File: rtl/controlador_conversao.sv
// Binary to decimal/hex/octal digit converter for 7-segment display.
// Optional AUTO_BASE_EN: periodic automatic base advance while displaying.
module controlador_conversao #(
  parameter int PERIODO_AUTO = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] valor_binario,
  input  logic       valor_valido,
  input  logic       botao_base,
  output logic [1:0] base_atual,
  output logic [3:0] digito_unidade,
  output logic [3:0] digito_dezena,
  output logic [3:0] digito_centena,
  output logic       ocupado,
  output logic       pronto
);

  typedef enum logic [1:0] {
    OCIOSO,
    CONVERTE,
    EXIBE
  } estado_t;

  estado_t     estado;
  logic [7:0]  valor;
  logic [7:0]  desloc;
  logic [11:0] bcd;
  logic [2:0]  passo;
  logic        pendente;
  logic        botao_ant;
  logic        borda;
  logic        evento;
  logic        avanca;
  logic        inicia;
  logic [7:0]  valor_novo;
  logic [19:0] dd_prox;
  logic [11:0] digitos;

  function automatic logic [1:0] prox_base(input logic [1:0] b);
    case (b)
      2'b00:   return 2'b01;
      2'b01:   return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // One double-dabble iteration: add-3 correction, then shift left.
  function automatic logic [19:0] dd_passo(
    input logic [11:0] b,
    input logic [7:0]  s
  );
    logic [11:0] a;
    a = b;
    if (a[3:0] >= 4'd5)   a[3:0]  = a[3:0]  + 4'd3;
    if (a[7:4] >= 4'd5)   a[7:4]  = a[7:4]  + 4'd3;
    if (a[11:8] >= 4'd5)  a[11:8] = a[11:8] + 4'd3;
    return {a[10:0], s, 1'b0};
  endfunction

  assign borda   = botao_base & ~botao_ant;
  assign dd_prox = dd_passo(bcd, desloc);

`ifdef AUTO_BASE_EN
  logic [31:0] cont_auto;
  logic        auto_evt;

  assign auto_evt = (estado == EXIBE) &&
                    (cont_auto == 32'(PERIODO_AUTO - 1));
  assign evento   = borda | auto_evt;

  // Counts only while EXIBE is held; any exit restarts from zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cont_auto <= '0;
    end else if (estado == EXIBE &&
                 !(valor_valido || evento || pendente)) begin
      cont_auto <= cont_auto + 32'd1;
    end else begin
      cont_auto <= '0;
    end
  end
`else
  assign evento = borda;
`endif

  always_comb begin
    avanca     = 1'b0;
    inicia     = 1'b0;
    valor_novo = valor_valido ? valor_binario : valor;
    if (estado == OCIOSO) begin
      avanca = evento;
      inicia = valor_valido;
    end else if (estado == EXIBE) begin
      avanca = evento | pendente;
      inicia = valor_valido | avanca;
    end
  end

  always_comb begin
    digitos = '0;
    case (base_atual)
      2'b00:   digitos = dd_prox[19:8];
      2'b01:   digitos = {4'h0, valor[7:4], valor[3:0]};
      2'b10:   digitos = {2'b00, valor[7:6], 1'b0, valor[5:3],
                          1'b0, valor[2:0]};
      default: digitos = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado         <= OCIOSO;
      base_atual     <= 2'b00;
      digito_unidade <= '0;
      digito_dezena  <= '0;
      digito_centena <= '0;
      ocupado        <= 1'b0;
      pronto         <= 1'b0;
      pendente       <= 1'b0;
      valor          <= '0;
      desloc         <= '0;
      bcd            <= '0;
      passo          <= '0;
      botao_ant      <= 1'b0;
    end else begin
      botao_ant <= botao_base;
      pronto    <= 1'b0;
      case (estado)
        OCIOSO, EXIBE: begin
          if (avanca) begin
            base_atual <= prox_base(base_atual);
            pendente   <= 1'b0;
          end
          if (inicia) begin
            valor   <= valor_novo;
            desloc  <= valor_novo;
            bcd     <= '0;
            passo   <= '0;
            ocupado <= 1'b1;
            estado  <= CONVERTE;
          end
        end
        CONVERTE: begin
          if (evento) pendente <= 1'b1;
          if (base_atual == 2'b00 && passo != 3'd7) begin
            bcd    <= dd_prox[19:8];
            desloc <= dd_prox[7:0];
            passo  <= passo + 3'd1;
          end else begin
            digito_centena <= digitos[11:8];
            digito_dezena  <= digitos[7:4];
            digito_unidade <= digitos[3:0];
            ocupado        <= 1'b0;
            pronto         <= 1'b1;
            estado         <= EXIBE;
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_controlador_conversao.sv
// Scoreboard bench for controlador_conversao: directed vectors,
// expected pronto cycle/base/digits queued, monitor compares.
module tb_controlador_conversao;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] valor_binario = '0;
  logic       valor_valido = 1'b0;
  logic       botao_base = 1'b0;
  logic [1:0] base_atual;
  logic [3:0] digito_unidade;
  logic [3:0] digito_dezena;
  logic [3:0] digito_centena;
  logic       ocupado;
  logic       pronto;

  typedef struct {
    int          cyc;
    logic [1:0]  base;
    logic [11:0] dig;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  controlador_conversao #(.PERIODO_AUTO(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .valor_binario (valor_binario),
    .valor_valido  (valor_valido),
    .botao_base    (botao_base),
    .base_atual    (base_atual),
    .digito_unidade(digito_unidade),
    .digito_dezena (digito_dezena),
    .digito_centena(digito_centena),
    .ocupado       (ocupado),
    .pronto        (pronto)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input int got, input int want);
    n_chk++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  function automatic logic [11:0] digs();
    return {digito_centena, digito_dezena, digito_unidade};
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset && pronto) begin
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pronto: got digits %0h base %0d",
                 digs(), base_atual);
      end else begin
        e = q.pop_front();
        chk("pronto_cycle", cyc, e.cyc);
        chk("pronto_base", base_atual, e.base);
        chk("pronto_digits", digs(), e.dig);
      end
    end
  end

  // One stimulus cycle; the expected pronto lands lat cycles later.
  task automatic stim(input bit vv, input logic [7:0] v,
                      input bit btn, input int lat,
                      input logic [1:0] b, input logic [11:0] d,
                      input bit push, output int k);
    @(posedge clk);
    #1;
    k = cyc;
    valor_binario = v;
    valor_valido  = vv;
    botao_base    = btn;
    if (push) q.push_back('{cyc + lat, b, d});
    @(posedge clk);
    #1;
    valor_valido = 1'b0;
    botao_base   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int k;
    int nb;
    #1;
    chk("reset_base", base_atual, 0);
    chk("reset_digits", digs(), 0);
    chk("reset_ocupado", ocupado, 0);
    chk("reset_pronto", pronto, 0);
    idle(2);
    #1 reset = 1'b0;

`ifdef AUTO_BASE_EN
    stim(1, 8'h20, 0, 9, 2'b00, 12'h032, 1, k);
    q.push_back('{k + 14, 2'b01, 12'h020});
    q.push_back('{k + 19, 2'b10, 12'h040});
    idle(22);
    #1 reset = 1'b1;
    #1 chk("auto_reset_base", base_atual, 0);
    idle(1);
    #1 reset = 1'b0;
`else
    // Button in OCIOSO: base only, no conversion, wraps 10->00.
    stim(0, 8'h00, 1, 0, 0, 0, 0, k);
    idle(3);
    #1 chk("idle_btn_base1", base_atual, 1);
    chk("idle_btn_ocupado", ocupado, 0);
    stim(0, 8'h00, 1, 0, 0, 0, 0, k);
    idle(3);
    #1 chk("idle_btn_base2", base_atual, 2);
    stim(0, 8'h00, 1, 0, 0, 0, 0, k);
    idle(3);
    #1 chk("idle_btn_base0", base_atual, 0);

    // Decimal 0xFF: 8 busy cycles, digits held meanwhile.
    stim(1, 8'hFF, 0, 9, 2'b00, 12'h255, 1, k);
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ocupado) nb++;
      if (i == 4) chk("hold_during_dec", digs(), 0);
    end
    chk("ocupado_cycles", nb, 8);

    stim(0, 8'h00, 1, 2, 2'b01, 12'h0FF, 1, k);
    @(negedge clk);
    chk("hex_ocupado", ocupado, 1);
    chk("hold_during_hex", digs(), 12'h255);
    idle(3);
    stim(1, 8'hAB, 0, 2, 2'b01, 12'h0AB, 1, k);
    idle(4);
    stim(0, 8'h00, 1, 2, 2'b10, 12'h253, 1, k);
    idle(4);
    stim(1, 8'hFF, 0, 2, 2'b10, 12'h377, 1, k);
    idle(4);
    stim(0, 8'h00, 1, 9, 2'b00, 12'h255, 1, k);
    idle(12);

    // Button plus ignored strobe during conversion of 0x64.
    stim(1, 8'h64, 0, 9, 2'b00, 12'h100, 1, k);
    q.push_back('{k + 11, 2'b01, 12'h064});
    idle(1);
    #1;
    botao_base    = 1'b1;
    valor_valido  = 1'b1;
    valor_binario = 8'h10;
    @(posedge clk);
    #1;
    botao_base   = 1'b0;
    valor_valido = 1'b0;
    idle(12);

    // Strobe and button together: new value in the new base.
    stim(1, 8'h3C, 1, 2, 2'b10, 12'h074, 1, k);
    idle(4);
    stim(0, 8'h00, 1, 9, 2'b00, 12'h060, 1, k);
    idle(12);

    // Reset mid-conversion of 0x99.
    stim(1, 8'h99, 0, 0, 0, 0, 0, k);
    idle(3);
    #1 reset = 1'b1;
    #1;
    chk("midreset_ocupado", ocupado, 0);
    chk("midreset_pronto", pronto, 0);
    chk("midreset_digits", digs(), 0);
    chk("midreset_base", base_atual, 0);
    idle(1);
    #1 reset = 1'b0;
    idle(12);
    stim(1, 8'h07, 0, 9, 2'b00, 12'h007, 1, k);
    idle(12);
`endif

    chk("queue_empty", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/controlador_conversao.md
CONTROLADOR_CONVERSAO -- requirements
Module: controlador_conversao

Interface
REQ-001 SHALL have parameter PERIODO_AUTO, default 50000000, number of clock cycles between automatic base advances (used only with AUTO_BASE_EN).
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port valor_binario  input  8  value to convert; sampled only when valor_valido=1.
REQ-005 SHALL have port valor_valido  input  1  one-cycle load strobe for valor_binario.
REQ-006 SHALL have port botao_base  input  1  base-select button, synchronous level, already debounced.
REQ-007 SHALL have port base_atual  output  2  current base: 00=decimal, 01=hexadecimal, 10=octal.
REQ-008 SHALL have ports digito_unidade, digito_dezena, digito_centena  output  4 each  registered digits for the 7-segment decoders.
REQ-009 SHALL have port ocupado  output  1  high while in state CONVERTE.
REQ-010 SHALL have port pronto  output  1  one-cycle pulse when new digits are presented.

Function
REQ-011 SHALL implement FSM states OCIOSO, CONVERTE, EXIBE.
REQ-012 SHALL, in OCIOSO or EXIBE with valor_valido=1, latch valor_binario into an internal register and enter CONVERTE.
REQ-013 SHALL, for base 00, perform sequential double-dabble: 8 CONVERTE cycles, one shift-add-3 iteration per cycle, on an 8-bit shift plus 12-bit BCD scratch register.
REQ-014 SHALL, for base 01, spend 1 CONVERTE cycle: dezena=value[7:4], unidade=value[3:0], centena=0.
REQ-015 SHALL, for base 10, spend 1 CONVERTE cycle: centena={00,value[7:6]}, dezena={0,value[5:3]}, unidade={0,value[2:0]}.
REQ-016 SHALL update the three digit outputs simultaneously on the CONVERTE->EXIBE edge, assert pronto for exactly that EXIBE cycle, and hold the digits unchanged during CONVERTE.
REQ-017 SHALL give latency from sampling edge of valor_valido to pronto=1 of 9 cycles (decimal) and 2 cycles (hex/octal).
REQ-018 SHALL ignore valor_valido while in CONVERTE (no latch, no restart).
REQ-019 SHALL detect rising edges of botao_base (registered previous level) and advance base_atual 00->01->10->00; base 11 SHALL never occur.
REQ-020 SHALL, on a button edge in EXIBE, advance base and re-enter CONVERTE using the latched value.
REQ-021 SHALL, on a button edge in OCIOSO, advance base only, without conversion.
REQ-022 SHALL, on a button edge in CONVERTE, set a one-deep pending flag (further edges are dropped); on completion the FSM SHALL pass through EXIBE (pronto pulse), then advance the base, clear the flag and reconvert.
REQ-023 SHALL, when valor_valido and a button edge coincide outside CONVERTE, apply both: advance base and convert the new value in the new base.
REQ-024 SHALL keep base_atual stable for the full duration of a conversion.

Reset
REQ-025 SHALL, with reset=1, asynchronously force state=OCIOSO, base_atual=00, all digits=0, ocupado=0, pronto=0, pending flag=0, latched value=0, button-edge register=0, auto counter=0.
REQ-026 SHALL abandon any conversion in progress at reset without producing a pronto pulse.

Configuration
REQ-027 SHALL, with macro AUTO_BASE_EN defined, count cycles in EXIBE and, when the count reaches PERIODO_AUTO-1, generate an internal advance event identical to a button edge and restart the count; the counter SHALL clear on leaving EXIBE.
REQ-028 SHALL, with AUTO_BASE_EN undefined, contain no auto counter; the base SHALL change only via botao_base.

Verification
REQ-029 SHALL check: base 00, value 0xFF strobed -> ocupado high 8 cycles, pronto 9 cycles after strobe, digits 2,5,5.
REQ-030 SHALL check: base 01, value 0xAB -> pronto 2 cycles after strobe, centena 0, dezena 0xA, unidade 0xB.
REQ-031 SHALL check: base 10, value 0xFF -> digits 3,7,7; next button edge -> base 00, reconversion gives 2,5,5.
REQ-032 SHALL check: value 0x64 in base 00; button edge during cycle 3 of CONVERTE plus valor_valido=0x10 -> first pronto shows 1,0,0; second shows hex 0,6,4; 0x10 never loaded.
REQ-033 SHALL check: reset asserted mid-conversion of 0x99 -> all outputs 0 immediately, no pronto, base 00, next strobe of 0x07 gives 0,0,7.
REQ-034 SHALL check (AUTO_BASE_EN, PERIODO_AUTO=4): in EXIBE with 0x20 decimal, after 4 idle cycles base advances to 01 and digits become 0,2,0.
